// File: rtl/st7735.sv
// st7735: ST7735 128x160 TFT power-up init and solid-colour fill engine.
// In: SYSTEM_CLK, SYSTEM_RST_N. Out: CS, MOSI, DC, LCD_CLK (SPI), RESET.
module st7735 #(
  parameter int unsigned DELAY_US   = 120000,
  parameter int unsigned CLK_MHZ    = 12,
  parameter logic [15:0] FILL_COLOR = 16'hF800,
  parameter int unsigned FILL_BYTES = 40960
) (
  input  logic SYSTEM_CLK,
  input  logic SYSTEM_RST_N,
  output logic CS,
  output logic MOSI,
  output logic DC,
  output logic LCD_CLK,
  output logic RESET
);

  localparam logic [31:0] DLY = 32'(DELAY_US * CLK_MHZ);
  localparam logic [4:0] ROM_LAST = 5'd16;
  localparam logic [4:0] CYC_LAST = 5'd19;
  localparam logic [15:0] PIX_LAST = 16'(FILL_BYTES - 1);

  typedef enum logic [2:0] {
    HW_RST,
    HW_WAIT,
    INIT,
    FILL,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0] cyc_q, cyc_d;
  logic [4:0] idx_q, idx_d;
  logic [15:0] pix_q, pix_d;
  logic pause_q, pause_d;
  logic data_q, data_d;

  logic [9:0] rom_w;
  logic [7:0] cur_byte;
  logic cur_dc;
  logic cur_dly;
  logic cnt_last;
  logic sending;
  logic adv;
  logic [2:0] bit_sel;

  // {post-delay, dc, byte}
  always_comb begin
    case (idx_q)
      5'd0:    rom_w = {2'b10, 8'h01};
      5'd1:    rom_w = {2'b10, 8'h11};
      5'd2:    rom_w = {2'b00, 8'h3A};
      5'd3:    rom_w = {2'b01, 8'h05};
      5'd4:    rom_w = {2'b00, 8'h36};
      5'd5:    rom_w = {2'b01, 8'h00};
      5'd6:    rom_w = {2'b00, 8'h2A};
      5'd7:    rom_w = {2'b01, 8'h00};
      5'd8:    rom_w = {2'b01, 8'h00};
      5'd9:    rom_w = {2'b01, 8'h00};
      5'd10:   rom_w = {2'b01, 8'h7F};
      5'd11:   rom_w = {2'b00, 8'h2B};
      5'd12:   rom_w = {2'b01, 8'h00};
      5'd13:   rom_w = {2'b01, 8'h00};
      5'd14:   rom_w = {2'b01, 8'h00};
      5'd15:   rom_w = {2'b01, 8'h9F};
      default: rom_w = {2'b10, 8'h29};
    endcase
  end

  // Byte on the wire; it stays selected through any post-delay so
  // DC and MOSI hold until the next byte starts.
  always_comb begin
    cur_dly  = 1'b0;
    cur_dc   = 1'b1;
    cur_byte = pix_q[0] ? FILL_COLOR[7:0]
                        : FILL_COLOR[15:8];
    if (state_q == HW_RST || state_q == HW_WAIT ||
        state_q == INIT) begin
      {cur_dly, cur_dc, cur_byte} = rom_w;
    end else if (!data_q) begin
      cur_dc   = 1'b0;
      cur_byte = 8'h2C;
    end
  end

  assign cnt_last = (cnt_q + 32'd1) >= DLY;
  assign sending  = (state_q == INIT || state_q == FILL) && !pause_q;
  assign bit_sel  = cyc_q[4] ? 3'd0 : 3'd7 - cyc_q[3:1];

  assign CS      = !(sending && cyc_q <= 5'd16);
  assign LCD_CLK = sending && cyc_q[0] && !cyc_q[4];
  assign MOSI    = cur_byte[bit_sel];
  assign DC      = cur_dc;
  assign RESET   = state_q != HW_RST;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    pix_d   = pix_q;
    pause_d = pause_q;
    data_d  = data_q;
    adv     = 1'b0;
    unique case (state_q)
      HW_RST, HW_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_last) begin
          cnt_d   = '0;
          cyc_d   = '0;
          idx_d   = '0;
          pause_d = 1'b0;
          state_d = (state_q == HW_RST) ? HW_WAIT : INIT;
        end
      end
      INIT, FILL: begin
        if (pause_q) begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_last) begin
            cnt_d   = '0;
            pause_d = 1'b0;
            adv     = 1'b1;
          end
        end else if (cyc_q != CYC_LAST) begin
          cyc_d = cyc_q + 5'd1;
        end else if (cur_dly && DLY > 32'd3) begin
          // Delay runs from CS rise; the 3 tail cycles count.
          pause_d = 1'b1;
          cnt_d   = 32'd3;
        end else begin
          adv = 1'b1;
        end
        if (adv) begin
          cyc_d = '0;
          if (state_q == INIT) begin
            idx_d = idx_q + 5'd1;
            if (idx_q == ROM_LAST) begin
              state_d = FILL;
              data_d  = 1'b0;
              pix_d   = '0;
            end
          end else if (!data_q) begin
            data_d = 1'b1;
          end else if (pix_q == PIX_LAST) begin
            state_d = DONE;
            cyc_d   = CYC_LAST;
          end else begin
            pix_d = pix_q + 16'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RST_N) begin
    if (!SYSTEM_RST_N) begin
      state_q <= HW_RST;
      cnt_q   <= '0;
      cyc_q   <= '0;
      idx_q   <= '0;
      pix_q   <= '0;
      pause_q <= 1'b0;
      data_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      pause_q <= pause_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_st7735.sv
// tb_st7735: directed bench for st7735 (D=24 cycles, 16-byte fill).
// Decodes SPI on LCD_CLK rises, times CS/RESET, watches protocol.
module tb_st7735;

  localparam int NFILL  = 16;
  localparam int NBYTES = 18 + NFILL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs, mosi, dc, lcd_clk, lcd_rst;

  always #5 clk = ~clk;

  st7735 #(
    .DELAY_US  (2),
    .CLK_MHZ   (12),
    .FILL_COLOR(16'hF800),
    .FILL_BYTES(NFILL)
  ) dut (
    .SYSTEM_CLK  (clk),
    .SYSTEM_RST_N(rst_n),
    .CS          (cs),
    .MOSI        (mosi),
    .DC          (dc),
    .LCD_CLK     (lcd_clk),
    .RESET       (lcd_rst)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic p_cs = 1'b1;
  logic p_lclk = 1'b0;
  logic p_dc = 1'b0;
  logic p_rst = 1'b0;
  int proto_err = 0;
  int rst_rise = -1;
  int nbits = 0;
  int nedge = 0;
  logic [7:0] sh = '0;
  logic bdc = 1'b0;
  int fall_t[$];
  int rise_t[$];
  int edges_q[$];
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      nbits = 0;
      nedge = 0;
    end else begin
      if (lcd_clk !== p_lclk && cs && p_cs) proto_err++;
      if (dc !== p_dc && !cs && !p_cs) proto_err++;
      if (lcd_rst && !p_rst) rst_rise = cyc;
      if (!cs && p_cs) begin
        fall_t.push_back(cyc);
        nedge = 0;
      end
      if (cs && !p_cs) begin
        rise_t.push_back(cyc);
        edges_q.push_back(nedge);
      end
      if (lcd_clk && !p_lclk) begin
        nedge++;
        sh = {sh[6:0], mosi};
        bdc = dc;
        nbits++;
        if (nbits == 8) begin
          got_q.push_back({bdc, sh});
          nbits = 0;
        end
      end
    end
    p_cs = cs;
    p_lclk = lcd_clk;
    p_dc = dc;
    p_rst = lcd_rst;
  end

  int rel;

  task automatic restart();
    @(negedge clk);
    #2;
    fall_t.delete();
    rise_t.delete();
    edges_q.delete();
    got_q.delete();
    rst_rise = -1;
    rel = cyc;
    rst_n = 1'b1;
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int t = 0;
    while (got_q.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(got_q.size() >= n), 32'd1);
  endtask

  initial begin
    int bad;
    int gexp;
    int t;
    exp_q = '{9'h001, 9'h011, 9'h03A, 9'h105, 9'h036,
              9'h100, 9'h02A, 9'h100, 9'h100, 9'h100,
              9'h17F, 9'h02B, 9'h100, 9'h100, 9'h100,
              9'h19F, 9'h029, 9'h02C};
    for (int i = 0; i < NFILL; i++)
      exp_q.push_back((i % 2 == 0) ? 9'h1F8 : 9'h100);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_lclk", 32'(lcd_clk), 32'd0);
    check("rst_reset", 32'(lcd_rst), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_dc", 32'(dc), 32'd0);

    restart();
    wait_bytes("wait_all", NBYTES);
    repeat (100) @(negedge clk);

    check("reset_low", 32'(rst_rise - rel), 32'd24);
    check("first_fall", 32'(fall_t[0] - rst_rise), 32'd24);
    check("byte_count", 32'(got_q.size()), 32'(NBYTES));
    check("fall_count", 32'(fall_t.size()), 32'(NBYTES));
    check("rise_count", 32'(rise_t.size()), 32'(NBYTES));
    for (int i = 0; i < NBYTES; i++)
      check($sformatf("byte%0d", i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFF,
            32'(exp_q[i]));
    check("cs_low", 32'(rise_t[0] - fall_t[0]), 32'd17);
    check("edges0", 32'(edges_q[0]), 32'd8);
    bad = 0;
    foreach (edges_q[i]) if (edges_q[i] != 8) bad++;
    check("edges_bad", 32'(bad), 32'd0);
    check("slot", 32'(fall_t[3] - fall_t[2]), 32'd20);
    check("post_dly0", 32'(fall_t[1] - rise_t[0]), 32'd24);
    bad = 0;
    for (int i = 0; i + 1 < fall_t.size(); i++) begin
      gexp = (i == 0 || i == 1 || i == 16) ? 24 : 3;
      if (fall_t[i + 1] - rise_t[i] != gexp) bad++;
    end
    check("gap_bad", 32'(bad), 32'd0);
    check("idle_cs", 32'(cs), 32'd1);
    check("idle_lclk", 32'(lcd_clk), 32'd0);
    check("idle_reset", 32'(lcd_rst), 32'd1);
    check("proto", 32'(proto_err), 32'd0);

    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    restart();
    wait_bytes("wait_mid", 3);
    t = 0;
    while (lcd_clk !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("mid_lclk_hi", 32'(lcd_clk), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_cs", 32'(cs), 32'd1);
    check("async_lclk", 32'(lcd_clk), 32'd0);
    check("async_reset", 32'(lcd_rst), 32'd0);
    repeat (2) @(negedge clk);
    restart();
    wait_bytes("wait_rerun", 3);
    check("rerun_rst", 32'(rst_rise - rel), 32'd24);
    check("rerun_fall", 32'(fall_t[0] - rst_rise), 32'd24);
    check("rerun_b0", 32'(got_q[0]), 32'h001);
    check("rerun_b1", 32'(got_q[1]), 32'h011);
    check("rerun_b2", 32'(got_q[2]), 32'h03A);
    check("proto_end", 32'(proto_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
